// File: rtl/seq_divider.sv
// Sequential 32-by-16 unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_ERR_FAST_EN: divide-by-zero/overflow skip the RUN phase.
module seq_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [4:0]  cnt_r, cnt_s;
  logic [15:0] dvd_lo_r, dvd_lo_s;
  logic [15:0] dvs_r, dvs_s;
  logic [16:0] rem_r, rem_s;
  logic [15:0] quo_sh_r, quo_sh_s;
  logic        dz_r, dz_s;
  logic        ov_r, ov_s;

  logic [15:0] quotient_s, remainder_s;
  logic        busy_s, done_s, div_zero_s, overflow_s;

  logic [3:0]  bit_idx_s;
  logic [16:0] trial_s;
  logic        ge_s;
  logic [16:0] rem_step_s;
  logic [15:0] fin_q_s, fin_r_s;
  logic        in_dz_s, in_ov_s;

  // Forced result for an erroneous operation: {quotient, remainder}.
  function automatic logic [31:0] err_result(input logic dz, input logic [15:0] lo);
    logic [31:0] res;
    if (dz) begin
      res = {16'hFFFF, lo};
    end else begin
      res = {16'hFFFF, 16'h0000};
    end
    return res;
  endfunction

  // One restoring step plus the final result selection.
  always_comb begin
    bit_idx_s  = 4'd15 - cnt_r[3:0];
    trial_s    = {rem_r[15:0], dvd_lo_r[bit_idx_s]};
    ge_s       = (trial_s >= {1'b0, dvs_r});
    rem_step_s = trial_s;
    if (ge_s) begin
      rem_step_s = trial_s - {1'b0, dvs_r};
    end else begin
      rem_step_s = trial_s;
    end
    fin_q_s = {quo_sh_r[14:0], ge_s};
    fin_r_s = rem_step_s[15:0];
    if (dz_r || ov_r) begin
      {fin_q_s, fin_r_s} = err_result(dz_r, dvd_lo_r);
    end else begin
      fin_q_s = {quo_sh_r[14:0], ge_s};
      fin_r_s = rem_step_s[15:0];
    end
    in_dz_s = (divisor == 16'h0000);
    in_ov_s = (divisor != 16'h0000) && (dividend[31:16] >= divisor);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    dvd_lo_s    = dvd_lo_r;
    dvs_s       = dvs_r;
    rem_s       = rem_r;
    quo_sh_s    = quo_sh_r;
    dz_s        = dz_r;
    ov_s        = ov_r;
    quotient_s  = quotient;
    remainder_s = remainder;
    busy_s      = busy;
    done_s      = 1'b0;
    div_zero_s  = div_zero;
    overflow_s  = overflow;
    case (state_r)
      IDLE: begin
        if (start) begin
          dvd_lo_s = dividend[15:0];
          dvs_s    = divisor;
          // R is seeded with the upper half; the 16 steps shift in the lower half.
          rem_s    = {1'b0, dividend[31:16]};
          cnt_s    = 5'd0;
          quo_sh_s = 16'h0000;
          dz_s     = in_dz_s;
          ov_s     = in_ov_s;
          state_s  = RUN;
          busy_s   = 1'b1;
`ifdef DIV_ERR_FAST_EN
          if (in_dz_s || in_ov_s) begin
            state_s                   = DONE;
            busy_s                    = 1'b0;
            done_s                    = 1'b1;
            {quotient_s, remainder_s} = err_result(in_dz_s, dividend[15:0]);
            div_zero_s                = in_dz_s;
            overflow_s                = in_ov_s;
          end else begin
            state_s = RUN;
          end
`endif
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        rem_s    = rem_step_s;
        quo_sh_s = {quo_sh_r[14:0], ge_s};
        cnt_s    = cnt_r + 5'd1;
        if (cnt_r == 5'd15) begin
          state_s     = DONE;
          busy_s      = 1'b0;
          done_s      = 1'b1;
          quotient_s  = fin_q_s;
          remainder_s = fin_r_s;
          div_zero_s  = dz_r;
          overflow_s  = ov_r;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 5'd0;
      dvd_lo_r  <= 16'h0000;
      dvs_r     <= 16'h0000;
      rem_r     <= 17'h00000;
      quo_sh_r  <= 16'h0000;
      dz_r      <= 1'b0;
      ov_r      <= 1'b0;
      quotient  <= 16'h0000;
      remainder <= 16'h0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      dvd_lo_r  <= dvd_lo_s;
      dvs_r     <= dvs_s;
      rem_r     <= rem_s;
      quo_sh_r  <= quo_sh_s;
      dz_r      <= dz_s;
      ov_r      <= ov_s;
      quotient  <= quotient_s;
      remainder <= remainder_s;
      busy      <= busy_s;
      done      <= done_s;
      div_zero  <= div_zero_s;
      overflow  <= overflow_s;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  seq_divider dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with the error rules layered on top.
  task automatic model(input logic [31:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic dz, output logic ov, output int lat);
    logic [31:0] qq;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 16'd0) begin
      dz = 1'b1;
      q  = 16'hFFFF;
      r  = a[15:0];
    end else begin
      qq = a / {16'd0, b};
      if (qq > 32'd65535) begin
        ov = 1'b1;
        q  = 16'hFFFF;
        r  = 16'h0000;
      end else begin
        q = qq[15:0];
        r = 16'(a % {16'd0, b});
      end
    end
    lat = 16;
`ifdef DIV_ERR_FAST_EN
    if (dz || ov) lat = 0;
`endif
  endtask

  // Issue one operation from IDLE; optionally poke a stray start at edge 'poke'.
  task automatic do_op(input logic [31:0] a, input logic [15:0] b, input int poke);
    logic [15:0] eq, er;
    logic        edz, eov;
    int          elat, lat;
    model(a, b, eq, er, edz, eov, elat);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    chk("busy_after_start", {31'd0, busy}, {31'd0, (elat != 0)});
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == poke) begin
        start    = 1'b1;
        dividend = 32'd7;
        divisor  = 16'd2;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("latency", lat, elat);
    chk("quotient", {16'd0, quotient}, {16'd0, eq});
    chk("remainder", {16'd0, remainder}, {16'd0, er});
    chk("div_zero", {31'd0, div_zero}, {31'd0, edz});
    chk("overflow", {31'd0, overflow}, {31'd0, eov});
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("quotient_held", {16'd0, quotient}, {16'd0, eq});
    chk("remainder_held", {16'd0, remainder}, {16'd0, er});
  endtask

  initial begin
    int          ndone, nbusy;
    logic [15:0] rb, up;
    logic [31:0] ra;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quotient", {16'd0, quotient}, 32'd0);
    chk("rst_remainder", {16'd0, remainder}, 32'd0);
    chk("rst_flags", {28'd0, busy, done, div_zero, overflow}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_op(32'd100000, 16'd300, -1);
    do_op(32'hFFFE0001, 16'hFFFF, -1);
    do_op(32'h00001234, 16'h0000, -1);
    do_op(32'h00050000, 16'h0005, -1);

    do_op(32'd100000, 16'd300, 5);
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (busy) nbusy++;
    end
    chk("no_queued_done", ndone, 0);
    chk("no_queued_busy", nbusy, 0);
    chk("held_after_idle", {quotient, remainder}, {16'd333, 16'd100});

    start    = 1'b1;
    dividend = 32'd100000;
    divisor  = 16'd300;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
    chk("abort_results", {quotient, remainder}, 32'd0);
    chk("abort_flags", {30'd0, div_zero, overflow}, 32'd0);
    @(posedge clk);
    #1;
    chk("abort_no_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    do_op(32'd1000, 16'd7, -1);

    for (int i = 0; i < 24; i++) begin
      case (i % 4)
        0: begin
          rb = 16'($urandom_range(1, 65535));
          up = 16'($urandom_range(0, int'(rb) - 1));
          ra = {up, 16'($urandom)};
        end
        1: begin
          rb = 16'($urandom_range(1, 255));
          ra = $urandom & 32'h0000FFFF;
        end
        2: begin
          rb = 16'($urandom);
          ra = $urandom;
        end
        default: begin
          rb = 16'd0;
          ra = $urandom;
        end
      endcase
      do_op(ra, rb, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
